spy_event_readout: RTL and testbench

//  Downstream readout stage for SpyController. On a start request it freezes the spy buffer and waits for in-flight writes to settle.
//  It then walks the metadata event list back from its write pointer, skipping sentinel (wrap) entries, to find the newest start-of-event address.
//  It streams that event's words, oldest first, from spy memory over a valid/ready interface, then releases freeze.

---
 rtl/spy_event_readout.sv | 227 ++++++++++++++++++++++
 tb/tb_spy_event_readout.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spy_event_readout.sv
`default_nettype none
// ============================================================================
// Module      : spy_event_readout
// Description : Readout stage for the spy buffer. On start it freezes the
//               buffer and waits for in-flight writes to land. It then walks
//               the event list back from its write pointer, skipping wrap
//               sentinels, to find the newest start-of-event. It streams that
//               event oldest-first through a 2-entry skid buffer and then
//               releases freeze.
// Revision    : 1.0  initial release
// ============================================================================
module spy_event_readout #(
  parameter int DATAWIDTH     = 64,
  parameter int MEMWIDTH      = 6,
  parameter int METAWIDTH     = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 resetbar,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic                 freeze,
  output logic [MEMWIDTH-1:0]  read_addr,
  output logic                 read_enable,
  input  logic [DATAWIDTH:0]   read_data,
  input  logic [MEMWIDTH-1:0]  mem_wptr,
  output logic [METAWIDTH-1:0] meta_read_addr,
  output logic                 meta_read_enable,
  input  logic [METAWIDTH-1:0] meta_write_addr,
  input  logic [MEMWIDTH:0]    meta_read_data,
  output logic [DATAWIDTH:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_SETTLE    = 3'd1;
  localparam logic [2:0] c_META_RD   = 3'd2;
  localparam logic [2:0] c_META_WAIT = 3'd3;
  localparam logic [2:0] c_EVAL      = 3'd4;
  localparam logic [2:0] c_STREAM    = 3'd5;
  localparam logic [2:0] c_DONE      = 3'd6;

  localparam int                    c_SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SW-1:0]       c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
  localparam logic [MEMWIDTH:0]     c_FULL_LEN    = {1'b1, {MEMWIDTH{1'b0}}};
  localparam logic [MEMWIDTH:0]     c_ONE         = {{MEMWIDTH{1'b0}}, 1'b1};

  logic [2:0]           r_state;
  logic [c_SW-1:0]      r_settle_cnt;
  logic [MEMWIDTH-1:0]  r_wp;
  logic [METAWIDTH-1:0] r_meta_addr;
  logic [MEMWIDTH:0]    r_meta_q;
  logic                 r_sentinel_seen;
  logic [MEMWIDTH-1:0]  r_rd_addr;
  logic [MEMWIDTH:0]    r_len;
  logic [MEMWIDTH:0]    r_issued;
  logic [MEMWIDTH:0]    r_sent;
  logic                 r_busy;
  logic                 r_freeze;
  logic                 r_done;
  logic [1:0]           r_status;

  logic                 r_pending;
  logic [DATAWIDTH:0]   r_buf0;
  logic [DATAWIDTH:0]   r_buf1;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic                 w_pop;
  logic [2:0]           w_occ;
  logic                 w_issue;
  logic                 w_last_hs;
  logic [MEMWIDTH:0]    w_eval_len;

  // Occupancy counts the word leaving this cycle as already gone, so a
  // steady 1 word/cycle stream is sustained while never exceeding 2 slots.
  always_comb begin
    w_pop      = out_valid && out_ready;
    w_occ      = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
    w_issue    = (r_state == c_STREAM) && (r_issued != r_len) && (w_occ < 3'd2);
    w_last_hs  = w_pop && out_last;
    w_eval_len = {1'b0, r_wp - r_meta_q[MEMWIDTH-1:0]};
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign status           = r_status;
  assign freeze           = r_freeze;
  assign read_addr        = r_rd_addr;
  assign read_enable      = w_issue;
  assign meta_read_addr   = r_meta_addr;
  assign meta_read_enable = (r_state == c_META_RD);
  assign out_valid        = (r_count != 2'd0);
  assign out_data         = r_rd_ptr ? r_buf1 : r_buf0;
  assign out_last         = out_valid && (r_sent == r_len - c_ONE);

  // Control FSM: settle, walk the event list, stream, report.
  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      r_state         <= c_IDLE;
      r_settle_cnt    <= '0;
      r_wp            <= '0;
      r_meta_addr     <= '0;
      r_meta_q        <= '0;
      r_sentinel_seen <= 1'b0;
      r_rd_addr       <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_sent          <= '0;
      r_busy          <= 1'b0;
      r_freeze        <= 1'b0;
      r_done          <= 1'b0;
      r_status        <= 2'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_state      <= c_SETTLE;
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
            r_freeze     <= 1'b1;
            r_status     <= 2'd0;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_SETTLE: begin
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_wp            <= mem_wptr;
            r_meta_addr     <= meta_write_addr - 1'b1;
            r_sentinel_seen <= 1'b0;
            r_state         <= c_META_RD;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        c_META_RD: begin
          r_state <= c_META_WAIT;
        end
        c_META_WAIT: begin
          r_meta_q <= meta_read_data;
          r_state  <= c_EVAL;
        end
        c_EVAL: begin
          r_issued <= '0;
          r_sent   <= '0;
          if (!r_meta_q[MEMWIDTH]) begin
            r_rd_addr <= r_meta_q[MEMWIDTH-1:0];
            r_len     <= w_eval_len;
            if (w_eval_len == '0) begin
              r_status <= 2'd1;
              r_state  <= c_DONE;
              r_busy   <= 1'b0;
              r_freeze <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= c_STREAM;
            end
          end else if (!r_sentinel_seen) begin
            r_sentinel_seen <= 1'b1;
            r_meta_addr     <= r_meta_addr - 1'b1;
            r_state         <= c_META_RD;
          end else begin
            // Two sentinels back to back: the event overran the whole
            // memory, so return the full ring starting at the oldest word.
            r_rd_addr <= r_wp;
            r_len     <= c_FULL_LEN;
            r_status  <= 2'd2;
            r_state   <= c_STREAM;
          end
        end
        c_STREAM: begin
          if (w_issue) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_issued  <= r_issued + 1'b1;
          end
          if (w_pop) begin
            r_sent <= r_sent + 1'b1;
          end
          if (w_last_hs) begin
            r_state  <= c_DONE;
            r_busy   <= 1'b0;
            r_freeze <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Skid buffer: capture read data one cycle after each issued read.
  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      r_pending <= 1'b0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      r_pending <= w_issue;
      if (r_pending) begin
        if (r_wr_ptr) begin
          r_buf1 <= read_data;
        end else begin
          r_buf0 <= read_data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_pending} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spy_event_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_spy_event_readout
// Description : Directed bench for spy_event_readout with behavioural spy
//               memory and event-list models (1-cycle read latency).
// Revision    : 1.0  initial release
// ============================================================================
module tb_spy_event_readout;

  localparam int DW = 64;
  localparam int MW = 6;
  localparam int XW = 4;
  localparam int SC = 3;

  logic          clock = 1'b0;
  logic          resetbar = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, freeze;
  logic [1:0]    status;
  logic [MW-1:0] read_addr;
  logic          read_enable;
  logic [DW:0]   read_data = '0;
  logic [MW-1:0] mem_wptr = '0;
  logic [XW-1:0] meta_read_addr;
  logic          meta_read_enable;
  logic [XW-1:0] meta_write_addr = '0;
  logic [MW:0]   meta_read_data = '0;
  logic [DW:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  logic [DW:0]   mem  [0:(1<<MW)-1];
  logic [MW:0]   meta [0:(1<<XW)-1];

  int n_cmp = 0;
  int n_err = 0;

  spy_event_readout #(
    .DATAWIDTH(DW), .MEMWIDTH(MW), .METAWIDTH(XW), .SETTLE_CYCLES(SC)
  ) dut (
    .clock(clock), .resetbar(resetbar), .start(start), .busy(busy),
    .done(done), .status(status), .freeze(freeze), .read_addr(read_addr),
    .read_enable(read_enable), .read_data(read_data), .mem_wptr(mem_wptr),
    .meta_read_addr(meta_read_addr), .meta_read_enable(meta_read_enable),
    .meta_write_addr(meta_write_addr), .meta_read_data(meta_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (read_enable) read_data <= mem[read_addr];
  always @(posedge clock) if (meta_read_enable) meta_read_data <= meta[meta_read_addr];

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] word_of(input logic [MW-1:0] a, input logic [7:0] tag);
    return {a[0] ^ tag[0], 24'hC0FFEE, tag, 26'h0, a};
  endfunction

  task automatic load(input logic [7:0] tag);
    for (int i = 0; i < (1 << MW); i++) mem[i] = word_of(MW'(i), tag);
    for (int i = 0; i < (1 << XW); i++) meta[i] = '0;
  endtask

  // SOE at 5 followed by 7 words: addresses 5..12, write pointer 13.
  task automatic setup_case1(input logic [7:0] tag);
    load(tag);
    meta[2]         = {1'b0, 6'd5};
    meta_write_addr = 4'd3;
    mem_wptr        = 6'd13;
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready toggles and a start is
  // pulsed mid-stream. abort_at>0: assert reset once that many words left.
  task automatic run_readout(input string name, input logic [7:0] tag,
                             input logic [MW-1:0] soe, input int cnt,
                             input logic [1:0] st, input int mode,
                             input int nreads, input int abort_at);
    int          n;
    bit          fin;
    bit          first_seen;
    bit          stalled;
    logic [DW:0] held;
    logic [MW-1:0] a;
    n = 0; fin = 0; first_seen = 0; stalled = 0; held = '0;
    @(negedge clock);
    start = 1'b1;
    for (int k = 1; k <= 400 && !fin; k++) begin
      @(negedge clock);
      start     = (mode == 1 && k == 20) ? 1'b1 : 1'b0;
      out_ready = (mode == 1) ? k[0] : 1'b1;
      if (abort_at > 0 && n == abort_at) begin
        check({name, " pre-reset valid"}, DW'(out_valid), 1);
        resetbar = 1'b0;
        #1;
        check({name, " reset freeze"}, DW'(freeze), 0);
        check({name, " reset valid"}, DW'(out_valid), 0);
        check({name, " reset busy"}, DW'(busy), 0);
        fin = 1;
      end else begin
        if (stalled) begin
          check({name, " hold valid"}, DW'(out_valid), 1);
          check({name, " hold data"}, out_data, held);
        end
        if (out_valid) begin
          if (!first_seen) begin
            first_seen = 1;
            check({name, " freeze during stream"}, DW'(freeze), 1);
            check({name, " busy during stream"}, DW'(busy), 1);
            if (mode == 0) check({name, " latency"}, DW'(k - 1), DW'(SC + 3 * nreads + 2));
          end
          if (out_ready) begin
            a = soe + MW'(n);
            check({name, " data"}, out_data, word_of(a, tag));
            check({name, " last"}, DW'(out_last), DW'(n == cnt - 1));
            n++;
          end
          stalled = !out_ready;
          held    = out_data;
        end else begin
          stalled = 0;
        end
        if (done) begin
          check({name, " status"}, DW'(status), DW'(st));
          check({name, " word count"}, DW'(n), DW'(cnt));
          check({name, " freeze released"}, DW'(freeze), 0);
          check({name, " busy at done"}, DW'(busy), 0);
          fin = 1;
          @(negedge clock);
          check({name, " done one cycle"}, DW'(done), 0);
        end
      end
    end
    if (!fin) check({name, " timeout"}, 0, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("reset busy", DW'(busy), 0);
    check("reset done", DW'(done), 0);
    check("reset status", DW'(status), 0);
    check("reset freeze", DW'(freeze), 0);
    check("reset read_enable", DW'(read_enable), 0);
    check("reset read_addr", DW'(read_addr), 0);
    check("reset meta_read_enable", DW'(meta_read_enable), 0);
    check("reset meta_read_addr", DW'(meta_read_addr), 0);
    check("reset out_valid", DW'(out_valid), 0);
    check("reset out_last", DW'(out_last), 0);
    check("reset out_data", out_data, 0);
    out_ready = 1'b0;
    resetbar  = 1'b1;
    @(negedge clock);

    setup_case1(8'h01);
    run_readout("t1", 8'h01, 6'd5, 8, 2'd0, 0, 1, 0);

    // SOE at 60 in entry 15, wrap sentinel in entry 0, list pointer 1.
    load(8'h02);
    meta[15]        = {1'b0, 6'd60};
    meta[0]         = {1'b1, 6'd0};
    meta_write_addr = 4'd1;
    mem_wptr        = 6'd6;
    run_readout("t2", 8'h02, 6'd60, 10, 2'd0, 0, 2, 0);

    // SOE at 10 then 130 words: two sentinels, write pointer 12.
    load(8'h03);
    meta[6]         = {1'b0, 6'd10};
    meta[7]         = {1'b1, 6'd0};
    meta[8]         = {1'b1, 6'd0};
    meta_write_addr = 4'd9;
    mem_wptr        = 6'd12;
    run_readout("t3", 8'h03, 6'd12, 64, 2'd2, 0, 2, 0);

    // SOE address equals write pointer: empty event.
    load(8'h04);
    meta[9]         = {1'b0, 6'd20};
    meta_write_addr = 4'd10;
    mem_wptr        = 6'd20;
    run_readout("t4", 8'h04, 6'd20, 0, 2'd1, 0, 1, 0);

    setup_case1(8'h05);
    run_readout("t5", 8'h05, 6'd5, 8, 2'd0, 1, 1, 0);

    setup_case1(8'h06);
    run_readout("t6a", 8'h06, 6'd5, 8, 2'd0, 0, 1, 2);
    @(negedge clock);
    resetbar = 1'b1;
    @(negedge clock);
    run_readout("t6b", 8'h06, 6'd5, 8, 2'd0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
